// File: rtl/sprite_draw_engine_if.sv
// Signal bundle between the game control FSM / VGA adapter and sprite_draw_engine.
// Pixel handshake: plot=1 presents x/y/colour. The pixel transfers on a rising edge where
// plot && plot_ready are both high, and x/y/colour hold steady until that edge.
interface sprite_draw_engine_if #(
  parameter int NUM_OBJ  = 2,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                        frame_tick;
  logic [NUM_OBJ*X_W-1:0]      obj_x;
  logic [NUM_OBJ*Y_W-1:0]      obj_y;
  logic [NUM_OBJ*COLOUR_W-1:0] obj_colour;
  logic [NUM_OBJ-1:0]          obj_en;
  logic                        plot_ready;
  logic [X_W-1:0]              x;
  logic [Y_W-1:0]              y;
  logic [COLOUR_W-1:0]         colour;
  logic                        plot;
  logic                        busy;
  logic                        done;
  logic                        hit;
  logic                        overrun;
  logic [1:0]                  state_dbg;

  modport master (
    output frame_tick, obj_x, obj_y, obj_colour, obj_en, plot_ready,
    input  x, y, colour, plot, busy, done, hit, overrun, state_dbg
  );

  modport slave (
    input  frame_tick, obj_x, obj_y, obj_colour, obj_en, plot_ready,
    output x, y, colour, plot, busy, done, hit, overrun, state_dbg
  );
endinterface

// File: rtl/sprite_draw_engine.sv
// Multi-object sprite renderer: per frame, erases each object at its previous position and
// redraws it at the new one, streaming pixels over a valid/ready handshake; reports collisions.
module sprite_draw_engine #(
  parameter int NUM_OBJ   = 2,
  parameter int SPR_W     = 8,
  parameter int SPR_H     = 8,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int COLOUR_W  = 3,
  parameter int BG_COLOUR = 0
) (
  input logic                 clock,
  input logic                 reset,
  sprite_draw_engine_if.slave bus
);
  localparam int IW  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int PXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int PYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [COLOUR_W-1:0] BG = COLOUR_W'(BG_COLOUR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state, next_state;
  logic [IW-1:0]  idx, next_idx;
  logic [PXW-1:0] px, next_px;
  logic [PYW-1:0] py, next_py;

  logic [X_W-1:0]      cur_x [NUM_OBJ];
  logic [Y_W-1:0]      cur_y [NUM_OBJ];
  logic [COLOUR_W-1:0] cur_colour [NUM_OBJ];
  logic [NUM_OBJ-1:0]  cur_en;
  logic [X_W-1:0]      prev_x [NUM_OBJ];
  logic [Y_W-1:0]      prev_y [NUM_OBJ];
  logic [NUM_OBJ-1:0]  prev_en;

  logic [X_W-1:0]      pixel_x;
  logic [Y_W-1:0]      pixel_y;
  logic [COLOUR_W-1:0] pixel_colour;
  logic                plot_on, busy_on, done_pulse, hit_flag, overrun_pulse;

  logic phase_en, phase_end, advance, last_pixel;
  logic next_erase, next_sweep, next_clip;
  logic [X_W-1:0]      next_x;
  logic [Y_W-1:0]      next_y;
  logic [COLOUR_W-1:0] next_colour;
  logic hit_next;
  int   dx, dy;

  // Sequencing: a phase ends when its object is disabled or its last pixel advances.
  // Clipped pixels are presented with plot=0, so !plot inside an enabled phase means "skip".
  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_px    = px;
    next_py    = py;
    phase_end  = 1'b0;
    phase_en   = (state == S_ERASE) ? prev_en[idx] : cur_en[idx];
    advance    = !plot_on || bus.plot_ready;
    last_pixel = (px == PXW'(SPR_W - 1)) && (py == PYW'(SPR_H - 1));
    case (state)
      S_IDLE: begin
        if (bus.frame_tick) begin
          next_state = S_ERASE;
          next_idx   = '0;
          next_px    = '0;
          next_py    = '0;
        end
      end
      S_ERASE, S_DRAW: begin
        if (!phase_en) begin
          phase_end = 1'b1;
        end else if (advance) begin
          if (last_pixel) begin
            phase_end = 1'b1;
          end else if (px == PXW'(SPR_W - 1)) begin
            next_px = '0;
            next_py = py + PYW'(1);
          end else begin
            next_px = px + PXW'(1);
          end
        end
        if (phase_end) begin
          next_px = '0;
          next_py = '0;
          if (state == S_ERASE) begin
            next_state = S_DRAW;
          end else if (idx == IW'(NUM_OBJ - 1)) begin
            next_state = S_DONE;
          end else begin
            next_state = S_ERASE;
            next_idx   = idx + IW'(1);
          end
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Pixel for the upcoming cycle, so x/y/colour/plot come straight from flops.
  always_comb begin
    next_erase  = (next_state == S_ERASE);
    next_sweep  = ((next_state == S_ERASE) && prev_en[next_idx]) ||
                  ((next_state == S_DRAW) && cur_en[next_idx]);
    next_x      = (next_erase ? prev_x[next_idx] : cur_x[next_idx]) + X_W'(next_px);
    next_y      = (next_erase ? prev_y[next_idx] : cur_y[next_idx]) + Y_W'(next_py);
    next_colour = next_erase ? BG : cur_colour[next_idx];
    next_clip   = (int'(next_x) >= SCREEN_W) || (int'(next_y) >= SCREEN_H);
  end

  // Distances are taken on unsigned coordinates widened to int, so they never wrap.
  always_comb begin
    hit_next = 1'b0;
    dx = 0;
    dy = 0;
    for (int j = 1; j < NUM_OBJ; j++) begin
      dx = int'(cur_x[0]) - int'(cur_x[j]);
      dy = int'(cur_y[0]) - int'(cur_y[j]);
      if (cur_en[0] && cur_en[j] && (dx < SPR_W) && (dx > -SPR_W) &&
          (dy < SPR_H) && (dy > -SPR_H)) begin
        hit_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      px            <= '0;
      py            <= '0;
      cur_en        <= '0;
      prev_en       <= '0;
      pixel_x       <= '0;
      pixel_y       <= '0;
      pixel_colour  <= '0;
      plot_on       <= 1'b0;
      busy_on       <= 1'b0;
      done_pulse    <= 1'b0;
      hit_flag      <= 1'b0;
      overrun_pulse <= 1'b0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        cur_x[k]      <= '0;
        cur_y[k]      <= '0;
        cur_colour[k] <= '0;
        prev_x[k]     <= '0;
        prev_y[k]     <= '0;
      end
    end else begin
      state         <= next_state;
      idx           <= next_idx;
      px            <= next_px;
      py            <= next_py;
      busy_on       <= (next_state != S_IDLE);
      done_pulse    <= (next_state == S_DONE);
      overrun_pulse <= bus.frame_tick && (state != S_IDLE);
      plot_on       <= next_sweep && !next_clip;
      if (next_sweep) begin
        pixel_x      <= next_x;
        pixel_y      <= next_y;
        pixel_colour <= next_colour;
      end
      if ((state == S_IDLE) && bus.frame_tick) begin
        cur_en <= bus.obj_en;
        for (int k = 0; k < NUM_OBJ; k++) begin
          cur_x[k]      <= bus.obj_x[k*X_W +: X_W];
          cur_y[k]      <= bus.obj_y[k*Y_W +: Y_W];
          cur_colour[k] <= bus.obj_colour[k*COLOUR_W +: COLOUR_W];
        end
      end
      if (next_state == S_DONE) begin
        hit_flag <= hit_next;
        prev_en  <= cur_en;
        for (int k = 0; k < NUM_OBJ; k++) begin
          prev_x[k] <= cur_x[k];
          prev_y[k] <= cur_y[k];
        end
      end
    end
  end

  assign bus.x         = pixel_x;
  assign bus.y         = pixel_y;
  assign bus.colour    = pixel_colour;
  assign bus.plot      = plot_on;
  assign bus.busy      = busy_on;
  assign bus.done      = done_pulse;
  assign bus.hit       = hit_flag;
  assign bus.overrun   = overrun_pulse;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_sprite_draw_engine.sv
// Bench for sprite_draw_engine: frame-level reference model feeds an expected-pixel queue,
// an independent monitor pops and compares every accepted pixel and each done/hit.
module tb_sprite_draw_engine;
  localparam int NUM_OBJ   = 2;
  localparam int SPR_W     = 8;
  localparam int SPR_H     = 8;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int COLOUR_W  = 3;
  localparam int BG_COLOUR = 0;
  localparam int PW        = X_W + Y_W + COLOUR_W;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sprite_draw_engine_if #(.NUM_OBJ(NUM_OBJ), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

  sprite_draw_engine #(
    .NUM_OBJ(NUM_OBJ), .SPR_W(SPR_W), .SPR_H(SPR_H), .X_W(X_W), .Y_W(Y_W),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .COLOUR_W(COLOUR_W), .BG_COLOUR(BG_COLOUR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  always #5 clock = ~clock;

  logic [PW-1:0] exp_q[$];
  logic          exp_hit_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int acc_count  = 0;
  int ready_mode = 0;
  int exp_cycles = 0;

  int m_px[NUM_OBJ];
  int m_py[NUM_OBJ];
  bit m_pe[NUM_OBJ];
  int cx[NUM_OBJ];
  int cy[NUM_OBJ];
  int cc[NUM_OBJ];
  bit ce[NUM_OBJ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: whole-frame behaviour from the rules, not cycle-level
  task automatic push_sweep(input int bx, input int by, input int col);
    for (int r = 0; r < SPR_H; r++) begin
      for (int c = 0; c < SPR_W; c++) begin
        int xx;
        int yy;
        xx = (bx + c) % (1 << X_W);
        yy = (by + r) % (1 << Y_W);
        if (xx < SCREEN_W && yy < SCREEN_H)
          exp_q.push_back({X_W'(xx), Y_W'(yy), COLOUR_W'(col)});
      end
    end
  endtask

  function automatic bit model_hit();
    bit h;
    h = 1'b0;
    for (int j = 1; j < NUM_OBJ; j++) begin
      int ax;
      int ay;
      ax = (cx[0] > cx[j]) ? cx[0] - cx[j] : cx[j] - cx[0];
      ay = (cy[0] > cy[j]) ? cy[0] - cy[j] : cy[j] - cy[0];
      if (ce[0] && ce[j] && ax < SPR_W && ay < SPR_H) h = 1'b1;
    end
    return h;
  endfunction

  task automatic model_frame();
    exp_cycles = 1;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (m_pe[i]) begin
        push_sweep(m_px[i], m_py[i], BG_COLOUR);
        exp_cycles += SPR_W * SPR_H;
      end else begin
        exp_cycles += 1;
      end
      if (ce[i]) begin
        push_sweep(cx[i], cy[i], cc[i]);
        exp_cycles += SPR_W * SPR_H;
      end else begin
        exp_cycles += 1;
      end
    end
    exp_hit_q.push_back(model_hit());
    for (int i = 0; i < NUM_OBJ; i++) begin
      m_px[i] = cx[i];
      m_py[i] = cy[i];
      m_pe[i] = ce[i];
    end
  endtask

  // driver tasks
  task automatic set_obj(input int k, input int xx, input int yy, input int col, input bit en);
    cx[k] = xx;
    cy[k] = yy;
    cc[k] = col;
    ce[k] = en;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    exp_q.delete();
    exp_hit_q.delete();
    for (int i = 0; i < NUM_OBJ; i++) m_pe[i] = 1'b0;
    reset = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clock);
    for (int k = 0; k < NUM_OBJ; k++) begin
      bus.obj_x[k*X_W +: X_W]                = X_W'(cx[k]);
      bus.obj_y[k*Y_W +: Y_W]                = Y_W'(cy[k]);
      bus.obj_colour[k*COLOUR_W +: COLOUR_W] = COLOUR_W'(cc[k]);
      bus.obj_en[k]                          = ce[k];
    end
    model_frame();
    bus.frame_tick = 1'b1;
    @(negedge clock);
    bus.frame_tick = 1'b0;
    // the frame must only use its snapshot
    bus.obj_x      = (NUM_OBJ*X_W)'($urandom());
    bus.obj_y      = (NUM_OBJ*Y_W)'($urandom());
    bus.obj_colour = (NUM_OBJ*COLOUR_W)'($urandom());
    bus.obj_en     = NUM_OBJ'($urandom());
  endtask

  // Called at the negedge of the first busy cycle; cycles counts that one as 1.
  task automatic wait_done(input int tick_at, output int cycles);
    cycles = 1;
    while (!bus.done && cycles < 5000) begin
      if (tick_at > 0 && cycles == tick_at) bus.frame_tick = 1'b1;
      @(negedge clock);
      cycles++;
      if (tick_at > 0 && cycles == tick_at + 1) begin
        bus.frame_tick = 1'b0;
        check("overrun_pulse", bus.overrun, 1);
      end
      if (tick_at > 0 && cycles == tick_at + 2) check("overrun_clear", bus.overrun, 0);
    end
    check("done_seen", bus.done, 1);
    @(negedge clock);
    check("done_one_cycle", bus.done, 0);
    check("idle_after_done", bus.busy, 0);
  endtask

  // plot_ready driver
  initial begin
    bus.plot_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       bus.plot_ready = 1'b1;
        1:       bus.plot_ready = !bus.plot_ready;
        default: bus.plot_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard monitor
  initial begin
    logic          stall;
    logic [PW-1:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_plot", bus.plot, 1);
          check("hold_pixel", {bus.x, bus.y, bus.colour}, held);
        end
        if (bus.plot && bus.plot_ready) begin
          acc_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pixel: got unexpected x=%0d y=%0d c=%0d, expected no pixel",
                     bus.x, bus.y, bus.colour);
          end else begin
            check("pixel", {bus.x, bus.y, bus.colour}, exp_q.pop_front());
          end
        end
        stall = bus.plot && !bus.plot_ready;
        held  = {bus.x, bus.y, bus.colour};
        if (bus.done) begin
          check("frame_pixels_left", exp_q.size(), 0);
          if (exp_hit_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL hit: got done with no frame outstanding, expected none");
          end else begin
            check("hit", bus.hit, exp_hit_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int guard;
    bus.frame_tick = 1'b0;
    bus.obj_x      = '0;
    bus.obj_y      = '0;
    bus.obj_colour = '0;
    bus.obj_en     = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      m_pe[i] = 1'b0;
      set_obj(i, 0, 0, 0, 1'b0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_plot", bus.plot, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hit", bus.hit, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_pixel", {bus.x, bus.y, bus.colour}, 0);

    // first frame: player only, no erase
    set_obj(0, 20, 60, 4, 1'b1);
    start_frame();
    check("s1_busy", bus.busy, 1);
    wait_done(0, cyc);
    check("s1_cycles", cyc, 68);
    check("s1_hit", bus.hit, 0);

    // player moves up two rows
    set_obj(0, 20, 58, 4, 1'b1);
    start_frame();
    wait_done(0, cyc);
    check("s2_cycles", cyc, 131);

    // backpressure on a fresh screen
    do_reset();
    ready_mode = 1;
    set_obj(0, 20, 60, 4, 1'b1);
    start_frame();
    wait_done(0, cyc);
    check("bp_cycles", (cyc == 131 || cyc == 132), 1);
    ready_mode = 0;

    // clipping at the bottom-right corner
    base = acc_count;
    set_obj(0, 156, 118, 4, 1'b1);
    start_frame();
    wait_done(0, cyc);
    check("clip_cycles", cyc, 131);
    check("clip_plots", acc_count - base, 64 + 8);

    // collision boundaries
    set_obj(0, 20, 60, 4, 1'b1);
    set_obj(1, 25, 62, 2, 1'b1);
    start_frame();
    wait_done(0, cyc);
    check("hit_overlap", bus.hit, 1);
    set_obj(1, 28, 60, 2, 1'b1);
    start_frame();
    wait_done(0, cyc);
    check("hit_dx_plus8", bus.hit, 0);
    set_obj(1, 12, 60, 2, 1'b1);
    start_frame();
    wait_done(0, cyc);
    check("hit_dx_minus8", bus.hit, 0);

    // frame_tick while busy
    set_obj(0, 40, 40, 5, 1'b1);
    set_obj(1, 90, 20, 3, 1'b1);
    start_frame();
    wait_done(10, cyc);
    check("overrun_frame_cycles", cyc, exp_cycles);

    // reset mid-sweep
    set_obj(0, 60, 30, 6, 1'b1);
    set_obj(1, 100, 50, 3, 1'b1);
    start_frame();
    base  = acc_count;
    guard = 0;
    while (acc_count - base < 30 && guard < 1000) begin
      @(negedge clock);
      #1;
      guard++;
    end
    check("pixels_before_reset", acc_count - base, 30);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_plot", bus.plot, 0);
    check("midrst_busy", bus.busy, 0);
    exp_q.delete();
    exp_hit_q.delete();
    for (int i = 0; i < NUM_OBJ; i++) m_pe[i] = 1'b0;
    reset = 1'b0;
    start_frame();
    wait_done(0, cyc);
    check("post_reset_no_erase", cyc, 1 + 64 + 1 + 64 + 1);

    // randomized frames
    for (int r = 0; r < 10; r++) begin
      ready_mode = $urandom_range(0, 2);
      set_obj(0, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
              1'($urandom_range(0, 3) != 0));
      for (int k = 1; k < NUM_OBJ; k++) begin
        if ($urandom_range(0, 1) == 1)
          set_obj(k, (cx[0] + $urandom_range(0, 20) + 246) % 256,
                  (cy[0] + $urandom_range(0, 20) + 118) % 128,
                  $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0));
        else
          set_obj(k, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
                  1'($urandom_range(0, 3) != 0));
      end
      start_frame();
      wait_done(0, cyc);
      if (ready_mode == 0) check("rand_cycles", cyc, exp_cycles);
    end
    ready_mode = 0;

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
